free_list: RTL and testbench

Physical-register free list for the R10K rename stage, sitting between dispatch (allocation side) and the ROB commit port (release side). It hands out new destination PRFs to dispatch lanes in order. On commit it reclaims the `old_prf` of each retiring writer. On a ROB flush it rewinds allocation to the committed point, so every speculatively allocated PRF returns to the list in one cycle. It is implemented as a circular buffer with three pointers: alloc head, retire head and tail.

---
 rtl/free_list.sv | 105 ++++++++++
 tb/tb_free_list.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
// Physical-register free list for the rename stage: a circular buffer of free PRF
// numbers with an allocation head, a retire head (committed point) and a tail.
module free_list #(
    parameter int PHYS_REGS      = 128,
    parameter int ARCH_REGS      = 64,
    parameter int DISPATCH_WIDTH = 2,
    parameter int COMMIT_WIDTH   = 2,
    localparam int PW            = $clog2(PHYS_REGS)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [DISPATCH_WIDTH-1:0]           alloc_req_i,
    output logic [DISPATCH_WIDTH-1:0]           alloc_gnt_o,
    output logic [DISPATCH_WIDTH-1:0][PW-1:0]   alloc_prf_o,
    output logic [PW:0]                         free_count_o,
    input  logic [COMMIT_WIDTH-1:0]             commit_valid_i,
    input  logic [COMMIT_WIDTH-1:0]             commit_rd_wen_i,
    input  logic [COMMIT_WIDTH-1:0][PW-1:0]     commit_old_prf_i,
    input  logic                                flush_i
);

    localparam logic [PW:0] FREE_INIT = (PW+1)'(PHYS_REGS - ARCH_REGS);

    logic [PW-1:0] entry_q [PHYS_REGS];
    logic [PW-1:0] entry_d [PHYS_REGS];
    logic [PW:0]   head_q, head_d;
    logic [PW:0]   rhead_q, rhead_d;
    logic [PW:0]   tail_q, tail_d;
    logic [PW:0]   free_count_q, free_count_d;

    logic [PW:0]   req_cnt;
    logic [PW:0]   gnt_cnt;
    logic [PW:0]   rel_cnt;
    logic [PW:0]   rd_ptr;
    logic [PW:0]   wr_ptr;
    logic [PW:0]   inflight_d;

    assign free_count_o = free_count_q;

    // Request/grant: a lane's grant is a same-cycle, no-backpressure acknowledgment;
    // dispatch consumes alloc_prf_o[i] in the cycle alloc_gnt_o[i] is high, and grants
    // always form an in-order prefix of the requesting lanes.
    always_comb begin
        alloc_gnt_o = '0;
        alloc_prf_o = '0;
        req_cnt     = '0;
        gnt_cnt     = '0;
        rd_ptr      = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            if (alloc_req_i[i]) begin
                req_cnt = req_cnt + 1'b1;
                if (!flush_i && reset && (req_cnt <= free_count_q)) begin
                    rd_ptr         = head_q + gnt_cnt;
                    alloc_gnt_o[i] = 1'b1;
                    alloc_prf_o[i] = entry_q[rd_ptr[PW-1:0]];
                    gnt_cnt        = gnt_cnt + 1'b1;
                end
            end
        end
    end

    // Releases pack into consecutive tail slots in lane order; lanes without rd_wen skip.
    always_comb begin
        entry_d = entry_q;
        rel_cnt = '0;
        wr_ptr  = '0;
        for (int c = 0; c < COMMIT_WIDTH; c++) begin
            if (commit_valid_i[c] && commit_rd_wen_i[c]) begin
                wr_ptr                  = tail_q + rel_cnt;
                entry_d[wr_ptr[PW-1:0]] = commit_old_prf_i[c];
                rel_cnt                 = rel_cnt + 1'b1;
            end
        end
        tail_d       = tail_q + rel_cnt;
        rhead_d      = rhead_q + rel_cnt;
        // A flush rewinds allocation to the committed point, including this cycle's commits.
        head_d       = flush_i ? rhead_d : (head_q + gnt_cnt);
        free_count_d = tail_d - head_d;
        inflight_d   = head_d - rhead_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PHYS_REGS; i++) begin
                entry_q[i] <= (i < PHYS_REGS - ARCH_REGS) ? PW'(ARCH_REGS + i) : '0;
            end
            head_q       <= '0;
            rhead_q      <= '0;
            tail_q       <= FREE_INIT;
            free_count_q <= FREE_INIT;
        end else begin
            entry_q      <= entry_d;
            head_q       <= head_d;
            rhead_q      <= rhead_d;
            tail_q       <= tail_d;
            free_count_q <= free_count_d;
        end
    end

    a_free_count_bound: assert property (@(posedge clk) disable iff (!reset)
        free_count_d <= FREE_INIT);
    a_rhead_not_past_head: assert property (@(posedge clk) disable iff (!reset)
        inflight_d <= FREE_INIT);

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: an order-preserving model of the free PRFs and
// of the speculative allocations feeds a scoreboard of expected granted PRFs.
module tb_free_list;

    localparam int PHYS_REGS = 128;
    localparam int ARCH_REGS = 64;
    localparam int PW        = $clog2(PHYS_REGS);
    localparam int N_FREE    = PHYS_REGS - ARCH_REGS;

    logic                 clk;
    logic                 reset;
    logic [1:0]           alloc_req;
    logic [1:0]           alloc_gnt;
    logic [1:0][PW-1:0]   alloc_prf;
    logic [PW:0]          free_count;
    logic [1:0]           commit_valid;
    logic [1:0]           commit_rd_wen;
    logic [1:0][PW-1:0]   commit_old_prf;
    logic                 flush;

    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] free_q[$];
    logic [PW-1:0] hist_q[$];
    logic [PW-1:0] live_q[$];
    logic          on_list [PHYS_REGS];
    logic          rand_mode;

    int n_checks;
    int n_errors;

    free_list #(
        .PHYS_REGS(PHYS_REGS), .ARCH_REGS(ARCH_REGS),
        .DISPATCH_WIDTH(2), .COMMIT_WIDTH(2)
    ) dut (
        .clk(clk), .reset(reset),
        .alloc_req_i(alloc_req), .alloc_gnt_o(alloc_gnt), .alloc_prf_o(alloc_prf),
        .free_count_o(free_count),
        .commit_valid_i(commit_valid), .commit_rd_wen_i(commit_rd_wen),
        .commit_old_prf_i(commit_old_prf), .flush_i(flush)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_init();
        free_q.delete();
        hist_q.delete();
        live_q.delete();
        exp_q.delete();
        for (int i = 0; i < PHYS_REGS; i++) begin
            on_list[i] = (i >= ARCH_REGS);
            if (i >= ARCH_REGS) free_q.push_back(PW'(i));
            else live_q.push_back(PW'(i));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        alloc_req    = 2'b11;
        flush        = 1'b0;
        commit_valid = 2'b00;
        reset        = 1'b0;
        #1;
        check("rst_gnt", alloc_gnt, 0);
        check("rst_count", free_count, N_FREE);
        model_init();
        @(negedge clk);
        reset     = 1'b1;
        alloc_req = 2'b00;
    endtask

    // Driver: one cycle of stimulus, grant/PRF checks before the edge, count after it.
    task automatic step(input logic [1:0] req, input logic fl, input logic [1:0] cv,
                        input logic [1:0] cw, input logic [PW-1:0] p0, input logic [PW-1:0] p1);
        logic [1:0]    gnt_e;
        logic [PW-1:0] g;
        logic [PW-1:0] rel;
        int            cnt;
        int            ngnt;
        @(negedge clk);
        alloc_req         = req;
        flush             = fl;
        commit_valid      = cv;
        commit_rd_wen     = cw;
        commit_old_prf[0] = p0;
        commit_old_prf[1] = p1;
        gnt_e = '0;
        cnt   = 0;
        ngnt  = 0;
        for (int i = 0; i < 2; i++) begin
            if (req[i]) begin
                cnt++;
                if (!fl && cnt <= free_q.size()) begin
                    gnt_e[i] = 1'b1;
                    exp_q.push_back(free_q[ngnt]);
                    ngnt++;
                end
            end
        end
        #1;
        check("alloc_gnt", alloc_gnt, gnt_e);
        for (int i = 0; i < 2; i++) begin
            if (alloc_gnt[i]) begin
                if (exp_q.size() == 0) begin
                    check("alloc_unexpected", alloc_gnt[i], 0);
                end else begin
                    g = exp_q.pop_front();
                    check("alloc_prf", alloc_prf[i], g);
                    if (rand_mode) check("prf_on_list", on_list[alloc_prf[i]], 1);
                end
            end
        end
        exp_q.delete();
        for (int n = 0; n < ngnt; n++) begin
            g = free_q.pop_front();
            hist_q.push_back(g);
            on_list[g] = 1'b0;
        end
        for (int c = 0; c < 2; c++) begin
            if (cv[c] && cw[c]) begin
                rel = (c == 1) ? p1 : p0;
                if (hist_q.size() > 0) begin
                    g = hist_q.pop_front();
                    if (rand_mode) live_q.push_back(g);
                end
                if (rand_mode) void'(live_q.pop_front());
                free_q.push_back(rel);
                on_list[rel] = 1'b1;
            end
        end
        if (fl) begin
            while (hist_q.size() > 0) begin
                g = hist_q.pop_back();
                free_q.push_front(g);
                on_list[g] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check("free_count", free_count, free_q.size());
    endtask

    initial begin
        logic [1:0]    cv;
        logic [1:0]    cw;
        logic [PW-1:0] p0;
        logic [PW-1:0] p1;
        int            maxq;
        int            nq;
        int            k;
        n_checks       = 0;
        n_errors       = 0;
        rand_mode      = 1'b0;
        reset          = 1'b0;
        alloc_req      = '0;
        flush          = 1'b0;
        commit_valid   = '0;
        commit_rd_wen  = '0;
        commit_old_prf = '0;
        do_reset();

        // Dual grant from reset, then a lane-1-only request.
        step(2'b11, 1'b0, 2'b00, 2'b00, '0, '0);
        step(2'b10, 1'b0, 2'b00, 2'b00, '0, '0);
        // Drain to one free entry, then a partial grant.
        for (int i = 0; i < 30; i++) step(2'b11, 1'b0, 2'b00, 2'b00, '0, '0);
        step(2'b11, 1'b0, 2'b00, 2'b00, '0, '0);
        // Empty list: release PRF 7 while requesting; it becomes grantable next cycle.
        step(2'b01, 1'b0, 2'b01, 2'b01, PW'(7), '0);
        step(2'b01, 1'b0, 2'b00, 2'b00, '0, '0);
        // Refill, and a valid-without-wen lane that must change nothing.
        for (int i = 0; i < 4; i++) step(2'b00, 1'b0, 2'b11, 2'b11, PW'(8 + 2*i), PW'(9 + 2*i));
        step(2'b00, 1'b0, 2'b11, 2'b00, PW'(40), PW'(41));
        step(2'b00, 1'b1, 2'b00, 2'b00, '0, '0);
        // Flush rewind: 6 allocations, 2 commits releasing 3 and 4, then flush.
        for (int i = 0; i < 3; i++) step(2'b11, 1'b0, 2'b00, 2'b00, '0, '0);
        step(2'b00, 1'b0, 2'b11, 2'b11, PW'(3), PW'(4));
        step(2'b11, 1'b1, 2'b00, 2'b00, '0, '0);
        step(2'b11, 1'b0, 2'b00, 2'b00, '0, '0);
        // Flush together with a committing writer on lane 1.
        step(2'b11, 1'b1, 2'b10, 2'b10, '0, PW'(20));
        step(2'b11, 1'b0, 2'b00, 2'b00, '0, '0);

        // Reset mid-operation, then randomized traffic long enough to wrap all pointers.
        do_reset();
        rand_mode = 1'b1;
        for (int t = 0; t < 400; t++) begin
            maxq = (hist_q.size() < 2) ? hist_q.size() : 2;
            nq   = $urandom_range(0, maxq);
            cv   = 2'($urandom_range(0, 3));
            cw   = 2'b00;
            if (nq == 2) begin
                cv = 2'b11;
                cw = 2'b11;
            end else if (nq == 1) begin
                k     = $urandom_range(0, 1);
                cv[k] = 1'b1;
                cw[k] = 1'b1;
            end
            p0 = PW'($urandom_range(0, PHYS_REGS - 1));
            p1 = PW'($urandom_range(0, PHYS_REGS - 1));
            k  = 0;
            if (cw[0]) begin
                p0 = live_q[k];
                k++;
            end
            if (cw[1]) p1 = live_q[k];
            step(2'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0), cv, cw, p0, p1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
